// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg -- shared constants and types for the MEM pipeline stage.
//   DATA_W / REG_ADDR_W : default datapath and register-index widths
//   mem_st_e            : bus-access FSM encoding (IDLE / WAIT / DONE)
package stage_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_st_e;

endpackage

// File: rtl/stage_mem.sv
// stage_mem -- memory stage. Passes ALU results straight to WB, or runs one
// load/store on a req/ack bus while holding the upstream stage, then commits
// the write-back result. A bus timeout aborts the access and sets a sticky
// error flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en, stall, flush          stage enable, downstream stall, bubble marker
//   reg_wr, reg_addr_rd       write-back request from EX
//   mem_rd, mem_wr            load / store (store wins if both)
//   alu_res, store_data       EX result (also address), store data
//   mem_req/we/addr/wdata     registered bus request
//   mem_ack, mem_rdata        one-cycle completion pulse, read data
//   stall_req                 combinational hold request to upstream
//   out_reg_wr/addr_rd/data   write-back to WB
//   out_flush                 bubble marker to WB
//   out_bus_err               sticky timeout flag
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_wr,
  input  logic [REG_ADDR_W-1:0] reg_addr_rd,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_req,
  output logic                  out_reg_wr,
  output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
  output logic [DATA_W-1:0]     out_reg_data,
  output logic                  out_flush,
  output logic                  out_bus_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Request fields latched at accept; upstream is not re-sampled afterwards.
  typedef struct packed {
    logic                  is_load;
    logic                  reg_wr;
    logic [REG_ADDR_W-1:0] rd;
  } pend_t;

  mem_st_e             state, state_nxt;
  pend_t               pend;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   cap_data;
  logic                cap_abort;

  logic                commit, memop, to_hit;
  logic                accept, req_clr, cnt_inc, cap_en, cap_abort_nxt, err_set;
  logic                wb_en, wb_wr, wb_flush;
  logic [DATA_W-1:0]   wb_data;
  logic [REG_ADDR_W-1:0] wb_rd;

  assign commit = en && !stall;
  assign memop  = en && !flush && (mem_rd || mem_wr);

  // Timeout fires on the last allowed WAIT cycle; an ack in that same cycle
  // is checked first in the FSM and therefore wins.
  if (TIMEOUT_CYC > 0) begin : g_to
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    assign to_hit = (cnt == CNT_LAST);
  end else begin : g_no_to
    assign to_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stall_req     = 1'b0;
    accept        = 1'b0;
    req_clr       = 1'b0;
    cnt_inc       = 1'b0;
    cap_en        = 1'b0;
    cap_abort_nxt = 1'b0;
    err_set       = 1'b0;
    wb_en         = 1'b0;
    wb_wr         = 1'b0;
    wb_flush      = 1'b0;
    wb_data       = '0;
    wb_rd         = pend.rd;
    case (state)
      MEM_ST_IDLE: begin
        if (memop) begin
          stall_req = 1'b1;
          accept    = 1'b1;
          state_nxt = MEM_ST_WAIT;
        end else if (commit) begin
          wb_en    = 1'b1;
          wb_wr    = reg_wr && !flush;
          wb_data  = alu_res;
          wb_rd    = reg_addr_rd;
          wb_flush = flush;
        end
      end
      MEM_ST_WAIT: begin
        stall_req = 1'b1;
        if (mem_ack) begin
          req_clr = 1'b1;
          if (commit) begin
            stall_req = 1'b0;
            wb_en     = 1'b1;
            wb_wr     = pend.is_load && pend.reg_wr;
            wb_data   = pend.is_load ? mem_rdata : mem_addr;
            state_nxt = MEM_ST_IDLE;
          end else begin
            cap_en    = 1'b1;
            state_nxt = MEM_ST_DONE;
          end
        end else if (to_hit) begin
          // Abort completes the instruction with write-back suppressed, so
          // upstream is released just as for an ack.
          req_clr = 1'b1;
          err_set = 1'b1;
          if (commit) begin
            stall_req = 1'b0;
            wb_en     = 1'b1;
            state_nxt = MEM_ST_IDLE;
          end else begin
            cap_en        = 1'b1;
            cap_abort_nxt = 1'b1;
            state_nxt     = MEM_ST_DONE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MEM_ST_DONE: begin
        stall_req = !commit;
        if (commit) begin
          wb_en     = 1'b1;
          wb_wr     = !cap_abort && pend.is_load && pend.reg_wr;
          wb_data   = cap_abort    ? '0 :
                      pend.is_load ? cap_data : mem_addr;
          state_nxt = MEM_ST_IDLE;
        end
      end
      default: state_nxt = MEM_ST_IDLE;
    endcase
  end

  // Bus request, pending request, counter and capture buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pend      <= '0;
      cnt       <= '0;
      cap_data  <= '0;
      cap_abort <= 1'b0;
    end else begin
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= mem_wr;
        mem_addr  <= alu_res;
        mem_wdata <= store_data;
        cnt       <= '0;
        pend      <= '{is_load: !mem_wr, reg_wr: reg_wr, rd: reg_addr_rd};
      end
      if (req_clr) mem_req <= 1'b0;
      if (cnt_inc) cnt <= cnt + 1'b1;
      if (cap_en) begin
        cap_data  <= cap_abort_nxt ? '0 : mem_rdata;
        cap_abort <= cap_abort_nxt;
      end
    end
  end

  // Write-back registers; out_bus_err only clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_reg_data    <= '0;
      out_flush       <= 1'b0;
      out_bus_err     <= 1'b0;
    end else begin
      if (err_set) out_bus_err <= 1'b1;
      if (wb_en) begin
        out_reg_wr      <= wb_wr;
        out_reg_addr_rd <= wb_rd;
        out_reg_data    <= wb_data;
        out_flush       <= wb_flush;
      end
    end
  end

endmodule
